// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns status and results.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one full-adder stage plus a carry
// flip-flop, LSB first, parallel result with carry-out and signed overflow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    // Single full-adder stage fed from the operand LSBs and the carry flop.
    always_comb begin
        fa_s  = opa_q[0] ^ opb_q[0] ^ c_q;
        fa_co = (opa_q[0] & opb_q[0]) |
                (opa_q[0] & c_q) |
                (opb_q[0] & c_q);
    end

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                opa_d = {1'b0, opa_q[WIDTH-1:1]};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                acc_d = {fa_s, acc_q[WIDTH-1:1]};
                c_d   = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    ovf_d   = c_q ^ fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d   = acc_q;
                carry_d    = c_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub at WIDTH=8 and WIDTH=4.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) bus8 ();
    serial_addsub_if #(.WIDTH(4)) bus4 ();

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic is, output logic [7:0] r,
                       output logic c, output logic v, output int lat);
        bus8.a     = ia;
        bus8.b     = ib;
        bus8.sub   = is;
        bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.done) begin
                lat = k;
                break;
            end
        end
        r = bus8.result;
        c = bus8.carry;
        v = bus8.overflow;
    endtask

    task automatic op4(input logic [3:0] ia, input logic [3:0] ib,
                       input logic is, output logic [3:0] r,
                       output logic c, output logic v, output int lat);
        bus4.a     = ia;
        bus4.b     = ib;
        bus4.sub   = is;
        bus4.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.done) begin
                lat = k;
                break;
            end
        end
        r = bus4.result;
        c = bus4.carry;
        v = bus4.overflow;
    endtask

    initial begin
        logic [7:0] r8;
        logic [3:0] r4;
        logic       c;
        logic       v;
        int         lat;
        int         ndone;
        int         done_at;

        vecs.push_back('{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0});

        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.sub   = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.sub   = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 0);
        chk("rst_done", 32'(bus8.done), 0);
        chk("rst_result", 32'(bus8.result), 0);
        chk("rst_carry", 32'(bus8.carry), 0);
        chk("rst_ovf", 32'(bus8.overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors run back-to-back: each start follows the prior done.
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, r8, c, v, lat);
            chk($sformatf("v%0d_res", i), 32'(r8), 32'(vecs[i].res));
            chk($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].c));
            chk($sformatf("v%0d_ovf", i), 32'(v), 32'(vecs[i].v));
            chk($sformatf("v%0d_lat", i), 32'(lat), 9);
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus8.done), 0);
        chk("hold_res", 32'(bus8.result), 32'h46);

        // Start pulsed while busy must be ignored.
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        bus8.sub   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int k = 4; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 8) chk($sformatf("t4_busy%0d", k), 32'(bus8.busy), 1);
            if (bus8.done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    chk("t4_res", 32'(bus8.result), 32'h30);
                end
            end
        end
        chk("t4_ndone", 32'(ndone), 1);
        chk("t4_done_at", 32'(done_at), 9);

        // Reset mid-run discards the operation and clears outputs.
        bus8.a     = 8'h33;
        bus8.b     = 8'h11;
        bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(bus8.busy), 0);
        chk("t5_done", 32'(bus8.done), 0);
        chk("t5_res", 32'(bus8.result), 0);
        op8(8'h01, 8'h01, 1'b0, r8, c, v, lat);
        chk("t5_new_res", 32'(r8), 32'h02);
        chk("t5_new_lat", 32'(lat), 9);

        // Reset and start together: reset wins, nothing runs.
        @(negedge clk);
        rst        = 1'b1;
        bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        bus8.start = 1'b0;
        chk("rs_busy", 32'(bus8.busy), 0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        chk("rs_ndone", 32'(ndone), 0);

        // Exhaustive WIDTH=4 sweep against a signed/unsigned arithmetic model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 2; is++) begin
                    int full;
                    int sa;
                    int sb;
                    int sr;
                    logic [4:0] fv;
                    logic ev;
                    full = (is != 0) ? ia + (15 - ib) + 1 : ia + ib;
                    fv = 5'(full);
                    sa = (ia >= 8) ? ia - 16 : ia;
                    sb = (ib >= 8) ? ib - 16 : ib;
                    sr = (is != 0) ? sa - sb : sa + sb;
                    ev = (sr < -8) || (sr > 7);
                    op4(4'(ia), 4'(ib), 1'(is), r4, c, v, lat);
                    chk($sformatf("w4_%0d_%0d_%0d_res", ia, ib, is),
                        32'(r4), 32'(fv[3:0]));
                    chk($sformatf("w4_%0d_%0d_%0d_c", ia, ib, is),
                        32'(c), 32'(fv[4]));
                    chk($sformatf("w4_%0d_%0d_%0d_v", ia, ib, is),
                        32'(v), 32'(ev));
                    chk($sformatf("w4_%0d_%0d_%0d_lat", ia, ib, is),
                        32'(lat), 5);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
